// File: rtl/shift_pkg.sv
// Shared decode constants and shifter encodings for the shift execution unit.
package shift_pkg;

    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;

    localparam logic [2:0] F3Left  = 3'b001;
    localparam logic [2:0] F3Right = 3'b101;

    localparam logic [6:0] F7Logic = 7'b0000000;
    localparam logic [6:0] F7Arith = 7'b0100000;
    localparam logic [6:0] F7Rot   = 7'b0110000;

    localparam logic [5:0] F6Logic = 6'b000000;
    localparam logic [5:0] F6Arith = 6'b010000;
    localparam logic [5:0] F6Rot   = 6'b011000;

    typedef enum logic [1:0] {
        ShiftLogic = 2'b00,
        ShiftArith = 2'b01,
        ShiftRot   = 2'b10
    } shift_op_e;

    localparam logic DirLeft  = 1'b0;
    localparam logic DirRight = 1'b1;

endpackage

// File: rtl/shifter.sv
// Combinational barrel shifter: logical/arithmetic/rotate, left/right, 64- or 32-bit mode.
module shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] operand_i,
    input  logic [5:0]       shamt_i,
    input  shift_op_e        op_i,
    input  logic             dir_i,
    input  logic             is32_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned HalfW = WIDTH / 2;

    logic        [HalfW-1:0]   word;
    logic        [2*WIDTH-1:0] rot_l;
    logic        [2*WIDTH-1:0] rot_r;
    logic        [WIDTH-1:0]   rot32_l;
    logic        [WIDTH-1:0]   rot32_r;
    logic signed [WIDTH-1:0]   asr64;
    logic signed [HalfW-1:0]   asr32;
    logic        [WIDTH-1:0]   res_d;
    logic        [HalfW-1:0]   res_w;

    assign word = operand_i[HalfW-1:0];

    // Rotates come from shifting a doubled copy of the operand.
    assign rot_l   = {operand_i, operand_i} << shamt_i;
    assign rot_r   = {operand_i, operand_i} >> shamt_i;
    assign rot32_l = {word, word} << shamt_i[4:0];
    assign rot32_r = {word, word} >> shamt_i[4:0];
    assign asr64   = $signed(operand_i) >>> shamt_i;
    assign asr32   = $signed(word) >>> shamt_i[4:0];

    always_comb begin
        res_d = '0;
        res_w = '0;
        case (op_i)
            ShiftLogic: begin
                res_d = (dir_i == DirRight) ? (operand_i >> shamt_i) : (operand_i << shamt_i);
                res_w = (dir_i == DirRight) ? (word >> shamt_i[4:0]) : (word << shamt_i[4:0]);
            end
            ShiftArith: begin
                res_d = (dir_i == DirRight) ? asr64 : (operand_i << shamt_i);
                res_w = (dir_i == DirRight) ? asr32 : (word << shamt_i[4:0]);
            end
            ShiftRot: begin
                res_d = (dir_i == DirRight) ? rot_r[WIDTH-1:0] : rot_l[2*WIDTH-1:WIDTH];
                res_w = (dir_i == DirRight) ? rot32_r[HalfW-1:0] : rot32_l[WIDTH-1:HalfW];
            end
            default: ;
        endcase
        result_o = is32_i ? {{HalfW{res_w[HalfW-1]}}, res_w} : res_d;
    end

endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage RISC-V shift execution unit: decode+operand register (S1), shifter result register (S2).
module shift_exec_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] funct6;
    logic       is_reg;
    logic       is_imm;
    shift_op_e  dec_op;
    logic       dec_dir;
    logic       dec_is32;
    logic [5:0] dec_shamt;
    logic       dec_illegal;

    logic             s1_valid_q, s1_valid_d;
    shift_op_e        s1_op_q, s1_op_d;
    logic             s1_dir_q, s1_dir_d;
    logic             s1_is32_q, s1_is32_d;
    logic [5:0]       s1_shamt_q, s1_shamt_d;
    logic [WIDTH-1:0] s1_operand_q, s1_operand_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_illegal_q, s1_illegal_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_illegal_q, s2_illegal_d;

    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] shift_result;
    logic             unused_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign funct6 = instr[31:26];

    assign unused_bits = ^{instr[19:15], instr[11:7], rs2_val[WIDTH-1:6]};

    always_comb begin
        is_reg      = 1'b0;
        is_imm      = 1'b0;
        dec_op      = ShiftLogic;
        dec_dir     = (funct3 == F3Right) ? DirRight : DirLeft;
        dec_is32    = 1'b0;
        dec_shamt   = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OpcOp: begin
                is_reg    = 1'b1;
                dec_shamt = rs2_val[5:0];
            end
            OpcOp32: begin
                is_reg    = 1'b1;
                dec_is32  = 1'b1;
                dec_shamt = {1'b0, rs2_val[4:0]};
            end
            OpcOpImm: begin
                is_imm    = 1'b1;
                dec_shamt = instr[25:20];
            end
            OpcOpImm32: begin
                is_imm      = 1'b1;
                dec_is32    = 1'b1;
                dec_shamt   = {1'b0, instr[24:20]};
                dec_illegal = instr[25];
            end
            default: dec_illegal = 1'b1;
        endcase
        if (funct3 != F3Left && funct3 != F3Right) begin
            dec_illegal = 1'b1;
        end
        // Arithmetic is right-only everywhere; immediate rotates are right-only too.
        if (is_reg) begin
            case (funct7)
                F7Logic: dec_op = ShiftLogic;
                F7Arith: begin
                    dec_op = ShiftArith;
                    if (dec_dir == DirLeft) dec_illegal = 1'b1;
                end
                F7Rot:   dec_op = ShiftRot;
                default: dec_illegal = 1'b1;
            endcase
        end else if (is_imm) begin
            case (funct6)
                F6Logic: dec_op = ShiftLogic;
                F6Arith: begin
                    dec_op = ShiftArith;
                    if (dec_dir == DirLeft) dec_illegal = 1'b1;
                end
                F6Rot: begin
                    dec_op = ShiftRot;
                    if (dec_dir == DirLeft) dec_illegal = 1'b1;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !flush && (!s1_valid_q || s1_adv);
    assign accept   = in_valid && in_ready;

    shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .operand_i(s1_operand_q),
        .shamt_i  (s1_shamt_q),
        .op_i     (s1_op_q),
        .dir_i    (s1_dir_q),
        .is32_i   (s1_is32_q),
        .result_o (shift_result)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_dir_d     = s1_dir_q;
        s1_is32_d    = s1_is32_q;
        s1_shamt_d   = s1_shamt_q;
        s1_operand_d = s1_operand_q;
        s1_tag_d     = s1_tag_q;
        s1_illegal_d = s1_illegal_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_tag_d     = s2_tag_q;
        s2_illegal_d = s2_illegal_q;

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d  = s1_illegal_q ? '0 : shift_result;
                s2_tag_d     = s1_tag_q;
                s2_illegal_d = s1_illegal_q;
            end
        end

        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_op_d      = dec_op;
            s1_dir_d     = dec_dir;
            s1_is32_d    = dec_is32;
            s1_shamt_d   = dec_shamt;
            s1_operand_d = rs1_val;
            s1_tag_d     = in_tag;
            s1_illegal_d = dec_illegal;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= ShiftLogic;
            s1_dir_q     <= DirLeft;
            s1_is32_q    <= 1'b0;
            s1_shamt_q   <= '0;
            s1_operand_q <= '0;
            s1_tag_q     <= '0;
            s1_illegal_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_tag_q     <= '0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_dir_q     <= s1_dir_d;
            s1_is32_q    <= s1_is32_d;
            s1_shamt_q   <= s1_shamt_d;
            s1_operand_q <= s1_operand_d;
            s1_tag_q     <= s1_tag_d;
            s1_illegal_q <= s1_illegal_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_tag_q     <= s2_tag_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_tag     = s2_tag_q;
    assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Self-checking bench for shift_exec_unit: directed cases plus random traffic against a bit-serial model.
module tb_shift_exec_unit;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          earliest;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    shift_exec_unit #(
        .WIDTH(64),
        .TAG_W(5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    function automatic logic [31:0] mk_i(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [5:0] f6, input logic [5:0] sh);
        return {f6, sh, 5'd1, f3, 5'd3, opc};
    endfunction

    // Reference: decode from the instruction fields, then shift one bit position at a time.
    function automatic void ref_model(input logic [31:0] ins, input logic [63:0] a,
                                      input logic [63:0] b, output logic ill,
                                      output logic [63:0] res);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        right, word, imm;
        int          kind, sh, n;
        logic [63:0] x;
        logic        msb, lsb;
        opc  = ins[6:0];
        f3   = ins[14:12];
        ill  = 1'b1;
        res  = 64'd0;
        kind = 0;
        word = (opc == 7'b0111011) || (opc == 7'b0011011);
        imm  = (opc == 7'b0010011) || (opc == 7'b0011011);
        if (!(opc == 7'b0110011 || opc == 7'b0111011 || imm)) return;
        if (f3 != 3'b001 && f3 != 3'b101) return;
        right = f3[2];
        if (imm) begin
            if (word && ins[25]) return;
            if (ins[31:26] == 6'b000000) kind = 0;
            else if (ins[31:26] == 6'b010000) kind = 1;
            else if (ins[31:26] == 6'b011000) kind = 2;
            else return;
            if (kind != 0 && !right) return;
            sh = word ? int'(ins[24:20]) : int'(ins[25:20]);
        end else begin
            if (ins[31:25] == 7'b0000000) kind = 0;
            else if (ins[31:25] == 7'b0100000) kind = 1;
            else if (ins[31:25] == 7'b0110000) kind = 2;
            else return;
            if (kind == 1 && !right) return;
            sh = word ? int'(b[4:0]) : int'(b[5:0]);
        end
        n = word ? 32 : 64;
        x = word ? {32'd0, a[31:0]} : a;
        for (int i = 0; i < sh; i++) begin
            msb = x[n-1];
            lsb = x[0];
            if (!right) begin
                x = x << 1;
                if (kind == 2) x[0] = msb;
            end else begin
                x = x >> 1;
                x[n-1] = (kind == 0) ? 1'b0 : (kind == 1) ? msb : lsb;
            end
        end
        if (word) x = {{32{x[31]}}, x[31:0]};
        ill = 1'b0;
        res = x;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] ins;
        r = $urandom;
        case ($urandom_range(0, 8))
            0, 1:    opc = 7'b0110011;
            2, 3:    opc = 7'b0111011;
            4, 5:    opc = 7'b0010011;
            6, 7:    opc = 7'b0011011;
            default: opc = r[6:0];
        endcase
        if ($urandom_range(0, 7) == 0) f3 = r[14:12];
        else f3 = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b001;
        case ($urandom_range(0, 6))
            0, 1:    f7 = 7'b0000000;
            2, 3:    f7 = 7'b0100000;
            4, 5:    f7 = 7'b0110000;
            default: f7 = r[31:25];
        endcase
        ins = {f7, r[24:15], f3, r[11:7], opc};
        if (opc == 7'b0011011 && $urandom_range(0, 3) != 0) ins[25] = 1'b0;
        return ins;
    endfunction

    // Transaction-level scoreboard: in-order queue, each entry visible no earlier than
    // two cycles after acceptance and one cycle after its predecessor left.
    int          cyc;
    exp_t        q[$];
    exp_t        e;
    logic        m_ready, m_valid, m_ill, prev_stall, prev_ill;
    logic [63:0] m_res, prev_res;
    logic [4:0]  prev_tag;

    initial begin
        cyc        = 0;
        prev_stall = 1'b0;
        prev_res   = '0;
        prev_tag   = '0;
        prev_ill   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                q.delete();
                prev_stall = 1'b0;
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_out_result", out_result, 64'd0);
                check("rst_out_tag", 64'(out_tag), 64'd0);
                check("rst_out_illegal", 64'(out_illegal), 64'd0);
            end else begin
                m_ready = !flush && (q.size() < 2 || out_ready);
                m_valid = (q.size() > 0) && (cyc >= q[0].earliest);
                check("in_ready", 64'(in_ready), 64'(m_ready));
                check("out_valid", 64'(out_valid), 64'(m_valid));
                if (m_valid && out_valid) begin
                    check("out_result", out_result, q[0].res);
                    check("out_tag", 64'(out_tag), 64'(q[0].tag));
                    check("out_illegal", 64'(out_illegal), 64'(q[0].ill));
                end
                if (prev_stall) begin
                    check("hold_result", out_result, prev_res);
                    check("hold_tag", 64'(out_tag), 64'(prev_tag));
                    check("hold_illegal", 64'(out_illegal), 64'(prev_ill));
                end
                prev_stall = out_valid && !out_ready && !flush;
                prev_res   = out_result;
                prev_tag   = out_tag;
                prev_ill   = out_illegal;
                if (flush) begin
                    q.delete();
                end else begin
                    if (m_valid && out_ready) begin
                        void'(q.pop_front());
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            if (e.earliest < cyc + 1) e.earliest = cyc + 1;
                            q.push_front(e);
                        end
                    end
                    if (in_valid && m_ready) begin
                        ref_model(instr, rs1_val, rs2_val, m_ill, m_res);
                        e.res      = m_res;
                        e.tag      = in_tag;
                        e.ill      = m_ill;
                        e.earliest = cyc + 2;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic lat_op(input string nm, input logic [31:0] ins, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tg,
                          input logic [63:0] er, input logic ei);
        int n;
        out_ready = 1'b1;
        instr     = ins;
        rs1_val   = a;
        rs2_val   = b;
        in_tag    = tg;
        in_valid  = 1'b1;
        @(negedge clk);
        check({nm, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check({nm, "_latency"}, 64'(n), 64'd2);
        check({nm, "_result"}, out_result, er);
        check({nm, "_tag"}, 64'(out_tag), 64'(tg));
        check({nm, "_illegal"}, 64'(out_illegal), 64'(ei));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b_ins[4];
    logic [63:0] b_a[4];
    logic [63:0] b_b[4];
    logic [4:0]  b_tag[4];
    logic [4:0]  g_tag[4];
    logic        g_ill[4];
    logic [63:0] g_res[4];

    task automatic burst(input int nb, input int stall, output int acc_in_stall, output int got);
        int k;
        k            = 0;
        got          = 0;
        acc_in_stall = 0;
        for (int c = 0; c < 40 && got < nb; c++) begin
            in_valid = (k < nb);
            if (k < nb) begin
                instr   = b_ins[k];
                rs1_val = b_a[k];
                rs2_val = b_b[k];
                in_tag  = b_tag[k];
            end
            out_ready = (c >= stall);
            @(negedge clk);
            if (in_valid && in_ready) begin
                k++;
                if (c < stall) acc_in_stall++;
            end
            if (out_valid && out_ready) begin
                if (got < 4) begin
                    g_tag[got] = out_tag;
                    g_ill[got] = out_illegal;
                    g_res[got] = out_result;
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic two_in_flight();
        out_ready = 1'b0;
        instr     = mk_r(7'b0110011, 3'b001, 7'b0000000);
        rs1_val   = 64'h5;
        rs2_val   = 64'd1;
        in_tag    = 5'd20;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_tag = 5'd21;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    logic        p_ill;
    logic [63:0] p_res;
    int          acc_st, got_n, quiet;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        rs1_val   = '0;
        rs2_val   = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        ref_model(mk_r(7'b0110011, 3'b001, 7'b0000000), 64'd1, 64'd63, p_ill, p_res);
        check("model_sll", p_res, 64'h8000000000000000);
        ref_model(mk_r(7'b0111011, 3'b101, 7'b0100000), 64'h80000000, 64'd4, p_ill, p_res);
        check("model_sraw", p_res, 64'hFFFFFFFFF8000000);
        ref_model(mk_i(7'b0011011, 3'b101, 6'b011000, 6'd1), 64'd1, 64'd0, p_ill, p_res);
        check("model_roriw", p_res, 64'hFFFFFFFF80000000);
        ref_model(mk_r(7'b0110011, 3'b001, 7'b0110000), 64'h8000000000000001, 64'd1, p_ill, p_res);
        check("model_rol", p_res, 64'h3);
        ref_model(mk_r(7'b0110011, 3'b001, 7'b0100000), 64'd1, 64'd1, p_ill, p_res);
        check("model_illegal", 64'(p_ill), 64'd1);

        lat_op("sll", mk_r(7'b0110011, 3'b001, 7'b0000000), 64'd1, 64'd63, 5'd1,
               64'h8000000000000000, 1'b0);
        lat_op("sraw", mk_r(7'b0111011, 3'b101, 7'b0100000), 64'h0000000080000000, 64'd4,
               5'd2, 64'hFFFFFFFFF8000000, 1'b0);
        lat_op("roriw", mk_i(7'b0011011, 3'b101, 6'b011000, 6'd1), 64'd1, 64'd0, 5'd3,
               64'hFFFFFFFF80000000, 1'b0);
        lat_op("sra_left", mk_r(7'b0110011, 3'b001, 7'b0100000), 64'hFFFF, 64'd3, 5'd4,
               64'd0, 1'b1);

        // Illegal op sandwiched between legal ones keeps program order.
        b_ins[0] = mk_r(7'b0110011, 3'b001, 7'b0000000);
        b_a[0] = 64'h1; b_b[0] = 64'd4; b_tag[0] = 5'd9;
        b_ins[1] = mk_r(7'b0110011, 3'b001, 7'b0100000);
        b_a[1] = 64'h7; b_b[1] = 64'd1; b_tag[1] = 5'd10;
        b_ins[2] = mk_r(7'b0110011, 3'b101, 7'b0000000);
        b_a[2] = 64'h100; b_b[2] = 64'd4; b_tag[2] = 5'd11;
        burst(3, 0, acc_st, got_n);
        check("order_count", 64'(got_n), 64'd3);
        check("order_tag1", 64'(g_tag[1]), 64'd10);
        check("order_ill0", 64'(g_ill[0]), 64'd0);
        check("order_ill1", 64'(g_ill[1]), 64'd1);
        check("order_res1", g_res[1], 64'd0);
        check("order_res2", g_res[2], 64'h10);

        for (int i = 0; i < 4; i++) begin
            b_ins[i] = mk_i(7'b0010011, 3'b001, 6'b000000, 6'(i + 1));
            b_a[i]   = 64'h3;
            b_b[i]   = 64'd0;
            b_tag[i] = 5'(12 + i);
        end
        burst(4, 3, acc_st, got_n);
        check("bp_accepts_in_stall", 64'(acc_st), 64'd2);
        check("bp_count", 64'(got_n), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("bp_tag", 64'(g_tag[i]), 64'(12 + i));
            check("bp_result", g_res[i], 64'h3 << (i + 1));
        end

        two_in_flight();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        out_ready = 1'b1;
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check("flush_no_out", 64'(quiet), 64'd0);
        @(posedge clk);
        #1;
        lat_op("after_flush", mk_r(7'b0110011, 3'b101, 7'b0110000), 64'h1, 64'd1, 5'd22,
               64'h8000000000000000, 1'b0);

        two_in_flight();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", 64'(in_ready), 64'd1);
        quiet = 0;
        repeat (4) begin
            if (out_valid) quiet++;
            @(negedge clk);
        end
        check("reset_no_out", 64'(quiet), 64'd0);
        @(posedge clk);
        #1;
        lat_op("after_reset", mk_r(7'b0111011, 3'b001, 7'b0000000), 64'h40000000, 64'd1, 5'd23,
               64'hFFFFFFFF80000000, 1'b0);

        for (int i = 0; i < 1200; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            rs1_val   = {$urandom, $urandom};
            rs2_val   = {$urandom, $urandom};
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst_n     = (i != 700);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/shift_exec_unit.md
SHIFT_EXEC_UNIT -- requirements
Module: shift_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning the datapath width; only 64 is supported.
REQ-002 SHALL have parameter TAG_W, default 5, meaning the width of the destination tag carried through the pipe.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning an issue request is present.
REQ-006 SHALL have port in_ready, output, 1, meaning the unit accepts the request this cycle.
REQ-007 SHALL have port instr, input, 32, the raw RISC-V instruction word.
REQ-008 SHALL have port rs1_val, input, WIDTH, the operand to shift.
REQ-009 SHALL have port rs2_val, input, WIDTH, the shift-amount source for register forms.
REQ-010 SHALL have port in_tag, input, TAG_W, the destination tag.
REQ-011 SHALL have port flush, input, 1, a synchronous kill of all in-flight operations.
REQ-012 SHALL have port out_valid, output, 1, meaning a result is present.
REQ-013 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-014 SHALL have port out_result, output, WIDTH, the shifted value.
REQ-015 SHALL have port out_tag, output, TAG_W, the tag of the result.
REQ-016 SHALL have port out_illegal, output, 1, meaning the instruction is not a supported shift.

Function
REQ-017 SHALL decode opcodes OP 0110011, OP-IMM 0010011, OP-32 0111011 and OP-IMM-32 0011011 with funct3 001 (left) or 101 (right); any other combination is illegal.
REQ-018 SHALL select by funct7 in register forms: 0000000 logical, 0100000 arithmetic (right only), 0110000 rotate; in OP-IMM by instr[31:26]: 000000 logical, 010000 arithmetic (right only), 011000 rotate (right only).
REQ-019 SHALL derive shamt as rs2_val[5:0] (OP), rs2_val[4:0] (OP-32), instr[25:20] (OP-IMM) or instr[24:20] (OP-IMM-32, which requires instr[25]=0, else illegal).
REQ-020 SHALL map the decode to the shifter encoding: op 00 logical, 01 arithmetic, 10 rotate; direction 0 left, 1 right; 32-bit mode for OP-32/OP-IMM-32.
REQ-021 SHALL be a 2-stage pipeline: S1 registers decoded fields, operand, tag and the illegal flag on acceptance; S2 registers the shifter output; out_valid rises exactly 2 cycles after acceptance with no stall.
REQ-022 SHALL accept when in_valid && in_ready; in_ready = !S1.valid || S1 advances this cycle, and S1 advances when !S2.valid || out_ready.
REQ-023 SHALL sustain one accepted operation per cycle while out_ready is held high.
REQ-024 SHALL hold out_result, out_tag and out_illegal stable while out_valid && !out_ready.
REQ-025 SHALL drive out_result all-zero when out_illegal=1; illegal ops still flow through the pipe and complete in order.
REQ-026 SHALL clear both stage valids on the edge where flush=1, deassert in_ready during the flush cycle, and take precedence over a simultaneous accept or handshake.
REQ-027 SHALL sign-extend every 32-bit-mode result from bit 31 to 64 bits.

Reset
REQ-028 SHALL, while rst_n=0, force out_valid=0, out_result=0, out_tag=0, out_illegal=0 and both stage valids to 0; in_ready SHALL be 1 from the first cycle after deassertion.
REQ-029 SHALL discard any in-flight operation when reset asserts mid-operation; no stale result appears after release.

Structure
REQ-030 SHALL place the opcode, funct3/funct7/funct6 constants, the shift-op enum (00/01/10) and the direction constants in a shared package, shift_pkg.
REQ-031 SHALL instantiate the existing shifter module once, between S1 and S2, and SHALL contain no other sub-module.

Verification
REQ-032 SHALL cover: SLL with rs1=1, rs2=63 -> 0x8000000000000000, out_valid 2 cycles after accept.
REQ-033 SHALL cover: SRAW with rs1=0x0000000080000000, rs2=4 -> 0xFFFFFFFFF8000000; RORIW with rs1=1, shamt 1 -> 0xFFFFFFFF80000000.
REQ-034 SHALL cover: funct3=001 with funct7=0100000 (OP) -> out_illegal=1, out_result=0, in program order.
REQ-035 SHALL cover: 4 back-to-back ops with out_ready low for 3 cycles -> in_ready drops after 2 accepts, output held stable, all 4 results delivered in order with correct tags.
REQ-036 SHALL cover: flush and rst_n pulses with 2 ops in flight -> no out_valid for either op; the next op completes with 2-cycle latency.
